// File: rtl/shift_register_from_instruction_memory.sv
// J-type jump target builder: a combinational index shift plus a one-deep
// valid/ready output register that holds {pc_plus4[31:28], index, 2'b00}.
module shift_register_from_instruction_memory (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [25:0] inpData,
   output logic [27:0] shiftedOutput,
   input  logic [31:0] pcPlus4,
   input  logic        in_valid,
   input  logic        out_ready,
   output logic        in_ready,
   output logic [31:0] jumpTarget,
   output logic        out_valid
);

   logic [31:0] jump_target_d, jump_target_q;
   logic        out_valid_d, out_valid_q;
   logic        capture;
   logic        unused_pc_bits;

   // Only the region nibble of PC+4 matters; the low bits are intentionally dropped.
   assign unused_pc_bits = ^pcPlus4[27:0];

   assign shiftedOutput = {inpData, 2'b00};

   assign in_ready = !out_valid_q || out_ready;
   assign capture  = in_valid && in_ready;

   always_comb begin
      jump_target_d = jump_target_q;
      out_valid_d   = out_valid_q;
      if (capture) begin
         // Concatenation, not addition: no carry may reach the region nibble.
         jump_target_d = {pcPlus4[31:28], inpData, 2'b00};
         out_valid_d   = 1'b1;
      end else if (out_ready) begin
         out_valid_d   = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         jump_target_q <= 32'h0000_0000;
         out_valid_q   <= 1'b0;
      end else begin
         jump_target_q <= jump_target_d;
         out_valid_q   <= out_valid_d;
      end
   end

   assign jumpTarget = jump_target_q;
   assign out_valid  = out_valid_q;

endmodule

// File: tb/tb_shift_register_from_instruction_memory.sv
// Randomized self-checking bench for the jump target builder, compared against
// an arithmetic reference of a one-entry output buffer.
module tb_shift_register_from_instruction_memory;

   logic        clk;
   logic        rst_n;
   logic [25:0] inpData;
   logic [27:0] shiftedOutput;
   logic [31:0] pcPlus4;
   logic        in_valid;
   logic        out_ready;
   logic        in_ready;
   logic [31:0] jumpTarget;
   logic        out_valid;

   int unsigned n_checks;
   int unsigned n_errors;

   // Reference model: one buffered entry and whether it is still unconsumed.
   logic [31:0] ref_target;
   logic        ref_full;

   shift_register_from_instruction_memory dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .inpData      (inpData),
      .shiftedOutput(shiftedOutput),
      .pcPlus4      (pcPlus4),
      .in_valid     (in_valid),
      .out_ready    (out_ready),
      .in_ready     (in_ready),
      .jumpTarget   (jumpTarget),
      .out_valid    (out_valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] exp_shift(input logic [25:0] d);
      return (32'(d) * 32'd4) & 32'h0fff_ffff;
   endfunction

   function automatic logic [31:0] exp_target(input logic [31:0] pc, input logic [25:0] d);
      return (pc & 32'hf000_0000) + 32'(d) * 32'd4;
   endfunction

   // One clock cycle: drive at the falling edge, check combinational outputs,
   // advance the model, then check registered outputs just after the rising edge.
   task automatic cycle(input logic v, input logic r, input logic [25:0] d,
                        input logic [31:0] pc);
      @(negedge clk);
      in_valid  = v;
      out_ready = r;
      inpData   = d;
      pcPlus4   = pc;
      #1;
      check_eq("shift", 32'(shiftedOutput), exp_shift(d));
      check_eq("in_ready", 32'(in_ready), 32'(!ref_full || r));
      if (v && (!ref_full || r)) begin
         ref_target = exp_target(pc, d);
         ref_full   = 1'b1;
      end else if (r) begin
         ref_full = 1'b0;
      end
      @(posedge clk);
      #1;
      check_eq("out_valid", 32'(out_valid), 32'(ref_full));
      check_eq("target", jumpTarget, ref_target);
   endtask

   initial begin
      logic [31:0] wide;
      n_checks   = 0;
      n_errors   = 0;
      ref_target = 32'h0;
      ref_full   = 1'b0;
      rst_n      = 1'b0;
      in_valid   = 1'b0;
      out_ready  = 1'b0;
      inpData    = 26'h0;
      pcPlus4    = 32'h0;

      #12;
      check_eq("rst_valid", 32'(out_valid), 32'h0);
      check_eq("rst_target", jumpTarget, 32'h0);
      check_eq("rst_in_ready", 32'(in_ready), 32'h1);

      // Combinational shift, exercised while still in reset.
      inpData = 26'h0000000; #1;
      check_eq("shift_zero", 32'(shiftedOutput), 32'h0000000);
      inpData = 26'h0000003; #1;
      check_eq("shift_three", 32'(shiftedOutput), 32'h000000c);
      inpData = 26'h3ffffff; #1;
      check_eq("shift_ones", 32'(shiftedOutput), 32'hffffffc);
      wide = 32'h0fff_ffff;
      inpData = wide[25:0]; #1;
      check_eq("shift_trunc", 32'(shiftedOutput), 32'hffffffc);

      @(negedge clk);
      rst_n = 1'b1;

      // First capture right after reset release.
      cycle(1'b1, 1'b0, 26'h0000003, 32'hA000_0004);
      check_eq("capture_const", jumpTarget, 32'hA000_000C);

      // Backpressure: held value, new requests ignored.
      for (int i = 0; i < 3; i++) begin
         cycle(1'b1, 1'b0, 26'($urandom), $urandom);
      end
      check_eq("bp_hold", jumpTarget, 32'hA000_000C);
      cycle(1'b1, 1'b1, 26'h0000010, 32'h5000_0000);
      check_eq("bp_release", jumpTarget, 32'h5000_0040);

      // Streaming: four back-to-back captures, then drain.
      for (int i = 0; i < 4; i++) begin
         cycle(1'b1, 1'b1, 26'($urandom), $urandom);
      end
      cycle(1'b0, 1'b1, 26'h0, 32'h0);
      check_eq("drained", 32'(out_valid), 32'h0);

      // Async reset between edges while holding a value.
      cycle(1'b1, 1'b0, 26'h1234567, 32'hC000_0000);
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check_eq("arst_valid", 32'(out_valid), 32'h0);
      check_eq("arst_target", jumpTarget, 32'h0);
      check_eq("arst_in_ready", 32'(in_ready), 32'h1);
      inpData = 26'h2aaaaaa;
      #1;
      check_eq("arst_shift", 32'(shiftedOutput), exp_shift(26'h2aaaaaa));
      ref_full   = 1'b0;
      ref_target = 32'h0;
      @(negedge clk);
      rst_n = 1'b1;
      cycle(1'b1, 1'b1, 26'h0000001, 32'hF000_0000);
      check_eq("post_arst_cap", jumpTarget, 32'hF000_0004);

      // Random traffic.
      for (int i = 0; i < 400; i++) begin
         cycle(1'($urandom), 1'($urandom), 26'($urandom), $urandom);
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
